// File: rtl/parity_rx_if.sv
// parity_rx_if: serial-in / word-out handshake bundle for parity_rx.
// Master drives the serial line and out_ready; slave returns the word.
interface parity_rx_if #(
  parameter int WIDTH = 16
);
  logic             ser_valid;
  logic             ser_bit;
  logic             ser_start;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport master (
    output ser_valid, ser_bit, ser_start, out_ready,
    input  out_valid, out_data, out_err
  );

  modport slave (
    input  ser_valid, ser_bit, ser_start, out_ready,
    output out_valid, out_data, out_err
  );
endinterface

// File: rtl/parity_rx.sv
// parity_rx: serial frame receiver, LSB-first data plus one parity bit,
// single-buffered word output with overrun flag and error counter.
module parity_rx #(
  parameter int WIDTH = 16,
  parameter bit ODD   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  parity_rx_if.slave  bus,
  input  logic        clr,
  output logic [7:0]  err_cnt,
  output logic        ovr,
  output logic        abort
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] PAR  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic [7:0]       ecnt_q, ecnt_d;
  logic             ovr_q, ovr_d;
  logic             abort_q, abort_d;
  logic             done;
  logic             ferr;
  logic             load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shr_d   = shr_q;
    abort_d = 1'b0;
    done    = 1'b0;
    ferr    = 1'b0;
    if (bus.ser_valid) begin
      if (bus.ser_start) begin
        // A start bit always begins a fresh frame, even mid-frame.
        abort_d  = (state_q != IDLE);
        shr_d    = '0;
        shr_d[0] = bus.ser_bit;
        cnt_d    = CW'(1);
        if (WIDTH == 1) begin
          state_d = PAR;
          cnt_d   = '0;
        end else begin
          state_d = DATA;
        end
      end else begin
        unique case (1'b1)
          (state_q == DATA): begin
            shr_d[cnt_q] = bus.ser_bit;
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_d = PAR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          (state_q == PAR): begin
            done    = 1'b1;
            ferr    = (^shr_q) ^ bus.ser_bit ^ ODD;
            state_d = IDLE;
            cnt_d   = '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign load = done && (!vld_q || bus.out_ready);

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    err_d  = err_q;
    ecnt_d = ecnt_q;
    ovr_d  = ovr_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = shr_q;
      err_d  = ferr;
      if (ferr && (ecnt_q != 8'hFF)) begin
        ecnt_d = ecnt_q + 8'd1;
      end
    end else if (done) begin
      ovr_d = 1'b1;
    end else if (vld_q && bus.out_ready) begin
      vld_d = 1'b0;
    end
    if (clr) begin
      ecnt_d = '0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shr_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
      ovr_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shr_q   <= shr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
      ovr_q   <= ovr_d;
      abort_q <= abort_d;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_err   = err_q;
  assign err_cnt       = ecnt_q;
  assign ovr           = ovr_q;
  assign abort         = abort_q;

endmodule

// File: doc/parity_rx.md
PARITY_RX -- requirements
Module: parity_rx

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, number of data bits per frame.
REQ-002 SHALL provide parameter ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ser_valid  input  1  ser_bit is valid this cycle.
REQ-007 ser_bit  input  1  serial line bit; data LSB first, then one parity bit.
REQ-008 ser_start  input  1  qualified by ser_valid; marks data bit 0 of a frame.
REQ-009 out_ready  input  1  downstream accepts the output word.
REQ-010 clr  input  1  synchronous clear of err_cnt and ovr.
REQ-011 out_valid  output  1  out_data and out_err hold a received frame.
REQ-012 out_data  output  WIDTH  received data word; first serial bit at bit 0.
REQ-013 out_err  output  1  parity mismatch for the word on out_data.
REQ-014 err_cnt  output  8  saturating count of delivered frames with parity errors.
REQ-015 ovr  output  1  sticky flag: a completed frame was dropped.
REQ-016 abort  output  1  one-cycle pulse: a partial frame was discarded.

Function
REQ-017 FSM states SHALL be IDLE, DATA and PAR; a bit SHALL be consumed only in a cycle with ser_valid=1, and gaps of any length SHALL be tolerated.
REQ-018 IDLE: ser_valid with ser_start SHALL store data bit 0 and go to DATA with bit count 1; ser_valid without ser_start SHALL be ignored.
REQ-019 DATA: each valid bit SHALL be stored at index = bit count; after bit WIDTH-1 the FSM SHALL go to PAR.
REQ-020 PAR: the valid bit SHALL be taken as parity p; err = (XOR of all data bits) XOR p XOR ODD; the FSM SHALL return to IDLE.
REQ-021 ser_start with ser_valid in DATA or PAR SHALL discard the partial frame, pulse abort in the next cycle, and treat the bit as data bit 0 of a new frame (DATA, count 1).
REQ-022 Frame completion SHALL load out_data and out_err and assert out_valid in the cycle after the parity bit, i.e. 1-cycle latency.
REQ-023 out_valid, out_data and out_err SHALL hold until a cycle with out_valid=1 and out_ready=1; out_valid SHALL then drop unless a new frame completes in the same cycle.
REQ-024 A frame completing while out_valid=1 and out_ready=0 SHALL be dropped; the output register SHALL be kept, ovr SHALL set, and err_cnt SHALL not change.
REQ-025 A frame completing in the same cycle as an output handshake SHALL be loaded with no overrun, and out_valid SHALL remain 1.
REQ-026 Reception SHALL continue while the output is pending; the output is single-buffered.
REQ-027 err_cnt SHALL increment by 1 when a frame with err=1 is loaded, and SHALL saturate at 255.
REQ-028 clr SHALL zero err_cnt and ovr next cycle; clr SHALL override a coincident increment or overrun.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, bit count 0, out_valid 0, out_data 0, out_err 0, err_cnt 0, ovr 0, abort 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release, IDLE SHALL wait for ser_start.

Verification
REQ-031 ODD=0: start, bits of 0x0001, p=1, out_ready=1 -> next cycle out_valid=1, out_data=0x0001, out_err=0, err_cnt=0.
REQ-032 ODD=0: 0xFFFF with p=1 -> out_err=1, err_cnt=1; ODD=1 build: 0x0000 with p=1 -> out_err=0.
REQ-033 out_ready=0, two good frames 0x1234 then 0xABCD -> out_data stays 0x1234, ovr=1; clr -> ovr=0.
REQ-034 ser_start re-asserted at data bit 7 -> abort=1 for one cycle; the next WIDTH+1 valid bits deliver exactly one word.
REQ-035 rst_n low at data bit 10 -> all outputs 0; the next full frame 0x5A5A (p=0) -> out_data=0x5A5A, out_err=0.
REQ-036 256 error frames with out_ready=1 -> err_cnt=255 held at 255; random ser_valid gaps -> identical results.
